// File: rtl/chess_sound_pkg.sv
// Shared types and constants for the chess sound path: arbiter FSM states,
// tone codes understood by the Sound block, and default requester slots.
package chess_sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam logic [2:0] SND_NONE    = 3'd0;
    localparam logic [2:0] SND_MOVE    = 3'd1;
    localparam logic [2:0] SND_CAPTURE = 3'd2;
    localparam logic [2:0] SND_CHECK   = 3'd3;
    localparam logic [2:0] SND_WIN     = 3'd4;
    localparam logic [2:0] SND_ILLEGAL = 3'd5;
    localparam logic [2:0] SND_CLICK   = 3'd6;

    // Requester slots; a higher index wins arbitration.
    localparam int unsigned CLICK    = 0;
    localparam int unsigned MOVE     = 1;
    localparam int unsigned CHECK    = 2;
    localparam int unsigned GAMEOVER = 3;

endpackage

// File: rtl/ms_timer.sv
// Millisecond-style timer: a TICK_DIV prescaler feeding a tick down-counter.
// load restarts both; expire pulses for one cycle on the last clock of the final tick.
module ms_timer #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned TW       = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          expire
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [TW-1:0] ticks_q;
    logic          tick;

    assign tick   = (presc_q == PW'(TICK_DIV - 1));
    assign expire = tick && (ticks_q == TW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
            ticks_q <= '0;
        end else if (load) begin
            presc_q <= '0;
            ticks_q <= value;
        end else if (ticks_q != '0) begin
            // Counter parks at zero once expired, so it can never wrap.
            if (tick) begin
                presc_q <= '0;
                ticks_q <= ticks_q - TW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Shares the single Sound tone generator between event sources: latches requests,
// grants by fixed priority, plays a timed tone and inserts a silent gap afterwards.
module sound_arbiter
    import chess_sound_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned TONE_MS  = 200,
    parameter int unsigned GAP_MS   = 20,
    parameter bit          PREEMPT  = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_code,
    input  logic              mute,
    output logic [2:0]        sound_code,
    output logic              play_sound,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam int unsigned MAX_MS = (TONE_MS > GAP_MS) ? TONE_MS : GAP_MS;
    localparam int unsigned TW     = $clog2(MAX_MS + 1);
    localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q;
    logic [NREQ-1:0] pending_q;
    logic [2:0]      slot_q [NREQ];
    logic [IW-1:0]   owner_q;

    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic            win_any;
    logic            start_play;
    logic            timer_load;
    logic [TW-1:0]   timer_value;
    logic            timer_exp;

    // Highest pending index wins; only registered pending is considered.
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pending_q[i]) begin
                win_idx = IW'(i);
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    assign win_any = |pending_q;

    always_comb begin
        start_play = 1'b0;
        if (!mute) begin
            unique case (state_q)
                IDLE: start_play = win_any;
                PLAY: start_play = (PREEMPT && win_any && (win_idx > owner_q)) ||
                                   (timer_exp && (GAP_MS == 0) && win_any);
                GAP:  start_play = timer_exp && win_any;
                default: start_play = 1'b0;
            endcase
        end
    end

    // Every state change reloads the timer, which also clears the prescaler.
    always_comb begin
        timer_load  = mute || start_play || (timer_exp && (state_q != IDLE));
        timer_value = '0;
        if (mute) begin
            timer_value = '0;
        end else if (start_play) begin
            timer_value = TW'(TONE_MS);
        end else if (state_q == PLAY) begin
            timer_value = TW'(GAP_MS);
        end
    end

    ms_timer #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_exp)
    );

    // Request capture; a same-cycle request beats the grant's clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= SND_NONE;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (mute) begin
                    pending_q[i] <= 1'b0;
                end else if (req[i] && (req_code[3*i +: 3] != SND_NONE)) begin
                    pending_q[i] <= 1'b1;
                    slot_q[i]    <= req_code[3*i +: 3];
                end else if (start_play && (win_idx == IW'(i))) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sound_code <= SND_NONE;
            play_sound <= 1'b0;
            grant      <= '0;
            owner_q    <= '0;
        end else begin
            grant <= '0;
            if (mute) begin
                state_q    <= IDLE;
                sound_code <= SND_NONE;
                play_sound <= 1'b0;
            end else if (start_play) begin
                state_q    <= PLAY;
                grant      <= win_onehot;
                sound_code <= slot_q[win_idx];
                play_sound <= 1'b1;
                owner_q    <= win_idx;
            end else if (timer_exp && (state_q != IDLE)) begin
                state_q    <= ((state_q == PLAY) && (GAP_MS != 0)) ? GAP : IDLE;
                sound_code <= SND_NONE;
                play_sound <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: one preempting and one non-preempting instance
// driven by the same stimulus (TICK_DIV=4, TONE_MS=3, GAP_MS=2).
module tb_sound_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] req_code = '0;
    logic        mute = 1'b0;

    logic [2:0]  sc, sc_np;
    logic        play, play_np;
    logic [3:0]  gnt, gnt_np;
    logic        busy, busy_np;

    int checks = 0;
    int errors = 0;
    int n, g, j, np_at, dut_play_n, dut_extra;
    logic [2:0] np_code;

    always #5 clk = ~clk;

    sound_arbiter #(
        .NREQ(4), .TICK_DIV(4), .TONE_MS(3), .GAP_MS(2), .PREEMPT(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_code(req_code), .mute(mute),
        .sound_code(sc), .play_sound(play), .grant(gnt), .busy(busy)
    );

    sound_arbiter #(
        .NREQ(4), .TICK_DIV(4), .TONE_MS(3), .GAP_MS(2), .PREEMPT(1'b0)
    ) dut_np (
        .clk(clk), .rstn(rstn), .req(req), .req_code(req_code), .mute(mute),
        .sound_code(sc_np), .play_sound(play_np), .grant(gnt_np), .busy(busy_np)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int idx, input logic [2:0] code);
        req[idx] = 1'b1;
        req_code[3*idx +: 3] = code;
        tick();
        req = '0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy || busy_np) && k < 200) begin
            tick();
            k++;
        end
        chk(tag, {30'd0, busy, busy_np}, 32'd0);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_play", play, 0);
        chk("rst_code", sc, 0);
        chk("rst_grant", gnt, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();

        // Single request: 12 tone cycles, 8 gap cycles
        pulse(1, 3'd1);
        tick();
        chk("t1_grant", gnt, 4'b0010);
        chk("t1_play", play, 1);
        chk("t1_code", sc, 1);
        chk("t1_busy", busy, 1);
        n = 0;
        while (play && n < 100) begin n++; tick(); end
        chk("t1_tone_len", n, 12);
        chk("t1_gap_code", sc, 0);
        chk("t1_gap_busy", busy, 1);
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        chk("t1_gap_len", n, 8);
        wait_idle("t1_idle");

        // Simultaneous requests: slot 2 first, slot 0 right after the gap
        req_code[2:0] = 3'd6;
        req_code[8:6] = 3'd3;
        req = 4'b0101;
        tick();
        req = '0;
        tick();
        chk("t2_grant_a", gnt, 4'b0100);
        chk("t2_code_a", sc, 3);
        n = 0;
        while (play && n < 100) begin n++; tick(); end
        n = 0;
        while (!play && busy && n < 100) begin n++; tick(); end
        chk("t2_gap_len", n, 8);
        chk("t2_grant_b", gnt, 4'b0001);
        chk("t2_code_b", sc, 6);
        chk("t2_play_b", play, 1);
        wait_idle("t2_idle");

        // Preemption vs. waiting, edge k = first pulse edge
        pulse(0, 3'd6);
        tick();
        chk("t3_grant0", gnt, 4'b0001);
        chk("t3_grant0_np", gnt_np, 4'b0001);
        repeat (4) tick();
        pulse(3, 3'd4);
        tick();
        chk("t3_pre_grant", gnt, 4'b1000);
        chk("t3_pre_code", sc, 4);
        chk("t3_pre_play", play, 1);
        chk("t3_np_grant", gnt_np, 0);
        chk("t3_np_code", sc_np, 6);
        dut_play_n = 1;
        dut_extra = 0;
        np_at = 0;
        np_code = 3'd0;
        for (j = 8; j <= 50; j++) begin
            tick();
            if (play) dut_play_n++;
            if (gnt != 0) dut_extra++;
            if (gnt_np == 4'b1000) begin
                np_at = j;
                np_code = sc_np;
            end
        end
        chk("t3_pre_len", dut_play_n, 12);
        chk("t3_no_replay", dut_extra, 0);
        chk("t3_np_at", np_at, 21);
        chk("t3_np_code3", np_code, 4);
        wait_idle("t3_idle");

        // Overwrite while waiting: plays the last code once
        pulse(3, 3'd4);
        tick();
        chk("t4_first", gnt, 4'b1000);
        pulse(2, 3'd2);
        pulse(2, 3'd5);
        n = 0;
        while (gnt == 0 && n < 100) begin n++; tick(); end
        chk("t4_ow_grant", gnt, 4'b0100);
        chk("t4_ow_code", sc, 5);
        g = 0;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
            if (gnt != 0) g++;
        end
        chk("t4_ow_once", g, 0);
        wait_idle("t4_ow_idle");

        // Set/clear collision in the grant cycle
        pulse(2, 3'd2);
        pulse(2, 3'd3);
        chk("t4_col_grant", gnt, 4'b0100);
        chk("t4_col_code", sc, 2);
        n = 1;
        tick();
        while (gnt == 0 && n < 100) begin n++; tick(); end
        chk("t4_col_delay", n, 20);
        chk("t4_col_regrant", gnt, 4'b0100);
        chk("t4_col_recode", sc, 3);
        wait_idle("t4_col_idle");

        // Mute mid-tone with two pending
        pulse(3, 3'd4);
        tick();
        pulse(1, 3'd1);
        pulse(2, 3'd2);
        tick();
        mute = 1'b1;
        tick();
        chk("t5_play", play, 0);
        chk("t5_code", sc, 0);
        chk("t5_busy", busy, 0);
        chk("t5_grant", gnt, 0);
        pulse(2, 3'd3);
        repeat (3) tick();
        mute = 1'b0;
        n = 0;
        repeat (30) begin
            tick();
            if (busy || gnt != 0) n++;
        end
        chk("t5_no_stale", n, 0);
        pulse(1, 3'd1);
        tick();
        chk("t5_resume", gnt, 4'b0010);
        wait_idle("t5_idle");

        // Asynchronous reset mid-tone
        pulse(1, 3'd1);
        tick();
        repeat (3) tick();
        chk("t6_pre_play", play, 1);
        rstn = 1'b0;
        #2;
        chk("t6_play", play, 0);
        chk("t6_code", sc, 0);
        chk("t6_busy", busy, 0);
        chk("t6_play_np", play_np, 0);
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        repeat (30) begin
            tick();
            if (busy) n++;
        end
        chk("t6_no_stale", n, 0);
        pulse(2, 3'd0);
        n = 0;
        repeat (5) begin
            tick();
            if (gnt != 0 || busy) n++;
        end
        chk("t6_code0_ignored", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
